uart_core_cfg: RTL and testbench
================================

// Module: uart_core_cfg
// PURPOSE
//  Parametrised UART core: runtime baud divisor, selectable parity, real TX/RX FIFOs with
//  valid/ready-style flags, per-byte error status and sticky overflow flags.
//  Sits between the serial pins and fabric logic. Replaces fixed-rate, fixed-payload UART tops.
//
// PARAMETERS
//  DBITS          8   data bits per frame (5..9)
//  SB_TICK        16  oversampling ticks per stop bit (16 = 1 stop, 32 = 2 stop)
//  DIV_BITS       16  width of runtime baud divisor
//  FIFO_EXP       4   log2 FIFO depth; both FIFOs hold 2**FIFO_EXP entries
//
// PORTS
//  clk_100MHz     in   1            system clock
//  reset          in   1            synchronous, active-high
//  baud_div       in   DIV_BITS     clocks per 16x oversample tick (0 treated as 1)
//  parity_mode    in   2            00 none, 01 even, 10 odd, 11 = none
//  rx             in   1            serial input (asynchronous)
//  tx             out  1            serial output, idle high
//  tx_wr          in   1            push tx_data into TX FIFO
//  tx_data        in   DBITS        byte to send
//  tx_full        out  1            TX FIFO full; tx_wr ignored
//  tx_busy        out  1            TX FIFO not empty OR TX FSM not IDLE
//  tx_overflow    out  1            sticky: tx_wr while tx_full
//  rx_rd          in   1            pop RX FIFO head (ignored when rx_empty)
//  rx_data        out  DBITS        RX FIFO head, first-word-fall-through
//  rx_parity_err  out  1            parity error flag of head entry
//  rx_frame_err   out  1            stop-bit error flag of head entry
//  rx_empty       out  1            RX FIFO empty
//  rx_full        out  1            RX FIFO full
//  rx_overrun     out  1            sticky: frame completed while rx_full (byte dropped)
//  err_clr        in   1            clears tx_overflow and rx_overrun
//
// BEHAVIOUR
//  Reset: tx=1, tx_busy=0, both FIFOs empty (rx_empty=1, tx_full=0, rx_full=0), sticky flags 0,
//   rx_data/err outputs 0, FSMs IDLE, tick counter 0, rx synchroniser flops = 1.
//   Reset mid-frame aborts immediately; tx high the cycle after reset is sampled.
//  Tick gen: counter increments each clock; when cnt >= max(baud_div,1)-1 -> tick=1, cnt=0.
//   Divisor change is safe mid-count (>= compare), takes effect at next wrap.
//  rx passes a 2-flop synchroniser before the FSM.
//  RX FSM: IDLE -> START on sync rx=0 (tick counter s=0). START: at s=7, rx still 0 -> DATA,
//   else IDLE (glitch reject). DATA: sample every 16 ticks, LSB first, DBITS bits.
//   PARITY (only if mode 01/10): sample 16 ticks later; perr = received != computed.
//   STOP: sample after 16 ticks; ferr = (rx==0); push {perr,ferr,data} then IDLE
//   once SB_TICK ticks elapsed. parity_mode latched at START entry.
//  RX push when full: entry dropped, rx_overrun=1; FIFO contents unchanged.
//  TX FSM: IDLE -> START when FIFO not empty: pop head, latch parity_mode, align to next tick.
//   START 16 ticks low; DATA 16 ticks/bit LSB first; PARITY 16 ticks (even: ^data,
//   odd: ~^data); STOP drives 1 for SB_TICK ticks; back IDLE, next byte with no gap.
//  Latency: tx_wr into empty idle core -> tx falls within 1 tick period + 3 clocks.
//  FIFOs: full/empty registered; simultaneous wr+rd allowed at any fill level except
//   wr at full (dropped even if same-cycle rd) and rd at empty (ignored, wr still lands).
//  err_clr same cycle as a new overflow/overrun event: set wins.
//
// TESTING
//  1 baud_div=4, mode 00, tx_wr 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1 each 64 clk; tx_busy 0 after stop.
//  2 loopback tx->rx, mode 01, send 0x00,0xFF,0x3C -> rx_data same order, both err flags 0;
//    parity bit on line 0,0,0; mode 10 -> 1,1,1.
//  3 mode 01, inject 0x01 with parity bit 0 -> entry perr=1; inject stop=0 -> ferr=1; next good
//    frame clean. rx low 3 ticks then high -> no push.
//  4 FIFO_EXP=4: 17 tx_wr back-to-back -> tx_full after 16th, tx_overflow=1, 16 bytes sent;
//    17 rx frames unread -> rx_overrun=1, first 16 bytes retained; err_clr -> flags 0.
//  5 reset asserted mid DATA bit 3 of TX and RX -> next cycle tx=1, rx_empty=1, tx_busy=0;
//    following 0x5A sent/received correctly.
//  6 baud_div changed 54->4 mid-idle and 0 -> tick every clock; frame width = 16*max(div,1)/bit.

Source files
------------

// File: rtl/uart_core_cfg.sv
// UART core: runtime baud divisor, selectable parity, TX/RX FIFOs with per-byte error status.
// UartCoreFifo is the first-word-fall-through FIFO used for both directions.

module UartCoreFifo #(
    parameter int WIDTH = 8,
    parameter int EXP   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 2 ** EXP;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [EXP-1:0]   wPtr_q, rPtr_q;
    logic [EXP:0]     count_q, count_d;
    logic             full_q, empty_q, doWr, doRd;

    assign doWr    = wr && !full_q;
    assign doRd    = rd && !empty_q;
    assign count_d = count_q + (EXP+1)'(doWr) - (EXP+1)'(doRd);

    always_ff @(posedge clk) begin
        if (reset) begin
            wPtr_q  <= '0;
            rPtr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (doWr) wPtr_q <= wPtr_q + EXP'(1);
            if (doRd) rPtr_q <= rPtr_q + EXP'(1);
            count_q <= count_d;
            full_q  <= (count_d == (EXP+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (doWr) mem[wPtr_q] <= wdata;
    end

    // Head reads as zero while empty so the outputs are defined straight out of reset.
    assign rdata = empty_q ? '0 : mem[rPtr_q];
    assign full  = full_q;
    assign empty = empty_q;
endmodule

module uart_core_cfg #(
    parameter int DBITS    = 8,
    parameter int SB_TICK  = 16,
    parameter int DIV_BITS = 16,
    parameter int FIFO_EXP = 4
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    input  logic [DIV_BITS-1:0] baud_div,
    input  logic [1:0]          parity_mode,
    input  logic                rx,
    output logic                tx,
    input  logic                tx_wr,
    input  logic [DBITS-1:0]    tx_data,
    output logic                tx_full,
    output logic                tx_busy,
    output logic                tx_overflow,
    input  logic                rx_rd,
    output logic [DBITS-1:0]    rx_data,
    output logic                rx_parity_err,
    output logic                rx_frame_err,
    output logic                rx_empty,
    output logic                rx_full,
    output logic                rx_overrun,
    input  logic                err_clr
);
    localparam int SW = $clog2(SB_TICK);
    localparam int NW = $clog2(DBITS);
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} UartState;

    logic [DIV_BITS-1:0] tickCnt_q, divMax;
    logic                tick;
    logic                rxSync1_q, rxSync2_q;

    // A >= compare lets a smaller divisor take effect without waiting for a long wrap.
    assign divMax = (baud_div == '0) ? '0 : baud_div - DIV_BITS'(1);
    assign tick   = (tickCnt_q >= divMax);

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            tickCnt_q <= '0;
            rxSync1_q <= 1'b1;
            rxSync2_q <= 1'b1;
        end else begin
            tickCnt_q <= tick ? '0 : tickCnt_q + DIV_BITS'(1);
            rxSync1_q <= rx;
            rxSync2_q <= rxSync1_q;
        end
    end

    UartState         rxState_q, rxState_d;
    logic [SW-1:0]    rxS_q, rxS_d;
    logic [NW-1:0]    rxN_q, rxN_d;
    logic [DBITS-1:0] rxB_q, rxB_d;
    logic [1:0]       rxMode_q, rxMode_d;
    logic             rxPerr_q, rxPerr_d, rxFerr_q, rxFerr_d, rxPush;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            rxState_q <= IDLE;
            rxS_q     <= '0;
            rxN_q     <= '0;
            rxB_q     <= '0;
            rxMode_q  <= '0;
            rxPerr_q  <= 1'b0;
            rxFerr_q  <= 1'b0;
        end else begin
            rxState_q <= rxState_d;
            rxS_q     <= rxS_d;
            rxN_q     <= rxN_d;
            rxB_q     <= rxB_d;
            rxMode_q  <= rxMode_d;
            rxPerr_q  <= rxPerr_d;
            rxFerr_q  <= rxFerr_d;
        end
    end

    always_comb begin
        rxState_d = rxState_q;
        rxS_d     = rxS_q;
        rxN_d     = rxN_q;
        rxB_d     = rxB_q;
        rxMode_d  = rxMode_q;
        rxPerr_d  = rxPerr_q;
        rxFerr_d  = rxFerr_q;
        rxPush    = 1'b0;
        case (rxState_q)
            IDLE: if (!rxSync2_q) begin
                rxState_d = START;
                rxS_d     = '0;
                rxMode_d  = parity_mode;
                rxPerr_d  = 1'b0;
                rxFerr_d  = 1'b0;
            end
            START: if (tick) begin
                if (rxS_q == S_MID) begin
                    rxS_d     = '0;
                    rxN_d     = '0;
                    rxState_d = rxSync2_q ? IDLE : DATA;
                end else rxS_d = rxS_q + SW'(1);
            end
            DATA: if (tick) begin
                if (rxS_q == S_BIT) begin
                    rxS_d = '0;
                    rxB_d = {rxSync2_q, rxB_q[DBITS-1:1]};
                    if (rxN_q == N_LAST) rxState_d = (rxMode_q[0] ^ rxMode_q[1]) ? PARITY : STOP;
                    else rxN_d = rxN_q + NW'(1);
                end else rxS_d = rxS_q + SW'(1);
            end
            PARITY: if (tick) begin
                if (rxS_q == S_BIT) begin
                    rxS_d     = '0;
                    rxPerr_d  = rxSync2_q != (rxMode_q[1] ? ~^rxB_q : ^rxB_q);
                    rxState_d = STOP;
                end else rxS_d = rxS_q + SW'(1);
            end
            STOP: if (tick) begin
                // Stop level is judged mid-bit; with two stop bits the push waits for the second.
                if (rxS_q == S_BIT) rxFerr_d = !rxSync2_q;
                if (rxS_q == S_STOP) begin
                    rxPush    = 1'b1;
                    rxState_d = IDLE;
                end else rxS_d = rxS_q + SW'(1);
            end
            default: rxState_d = IDLE;
        endcase
    end

    UartCoreFifo #(.WIDTH(DBITS + 2), .EXP(FIFO_EXP)) rxFifo (
        .clk   (clk_100MHz),
        .reset (reset),
        .wr    (rxPush),
        .wdata ({rxPerr_q, rxFerr_d, rxB_q}),
        .rd    (rx_rd),
        .rdata ({rx_parity_err, rx_frame_err, rx_data}),
        .full  (rx_full),
        .empty (rx_empty)
    );

    UartState         txState_q, txState_d;
    logic [SW-1:0]    txS_q, txS_d;
    logic [NW-1:0]    txN_q, txN_d;
    logic [DBITS-1:0] txB_q, txB_d, txHead;
    logic             txPar_q, txPar_d, txParEn_q, txParEn_d, tx_q, tx_d, txPop, txEmpty;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            txState_q <= IDLE;
            txS_q     <= '0;
            txN_q     <= '0;
            txB_q     <= '0;
            txPar_q   <= 1'b0;
            txParEn_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            txState_q <= txState_d;
            txS_q     <= txS_d;
            txN_q     <= txN_d;
            txB_q     <= txB_d;
            txPar_q   <= txPar_d;
            txParEn_q <= txParEn_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        txState_d = txState_q;
        txS_d     = txS_q;
        txN_d     = txN_q;
        txB_d     = txB_q;
        txPar_d   = txPar_q;
        txParEn_d = txParEn_q;
        txPop     = 1'b0;
        case (txState_q)
            IDLE: if (!txEmpty && tick) begin
                txPop     = 1'b1;
                txB_d     = txHead;
                txParEn_d = parity_mode[0] ^ parity_mode[1];
                txPar_d   = parity_mode[1] ? ~^txHead : ^txHead;
                txS_d     = '0;
                txState_d = START;
            end
            START: if (tick) begin
                if (txS_q == S_BIT) begin
                    txS_d     = '0;
                    txN_d     = '0;
                    txState_d = DATA;
                end else txS_d = txS_q + SW'(1);
            end
            DATA: if (tick) begin
                if (txS_q == S_BIT) begin
                    txS_d = '0;
                    txB_d = txB_q >> 1;
                    if (txN_q == N_LAST) txState_d = txParEn_q ? PARITY : STOP;
                    else txN_d = txN_q + NW'(1);
                end else txS_d = txS_q + SW'(1);
            end
            PARITY: if (tick) begin
                if (txS_q == S_BIT) begin
                    txS_d     = '0;
                    txState_d = STOP;
                end else txS_d = txS_q + SW'(1);
            end
            STOP: if (tick) begin
                // Chain straight into the next start bit so queued bytes leave without a gap.
                if (txS_q == S_STOP) begin
                    txS_d = '0;
                    if (!txEmpty) begin
                        txPop     = 1'b1;
                        txB_d     = txHead;
                        txParEn_d = parity_mode[0] ^ parity_mode[1];
                        txPar_d   = parity_mode[1] ? ~^txHead : ^txHead;
                        txState_d = START;
                    end else txState_d = IDLE;
                end else txS_d = txS_q + SW'(1);
            end
            default: txState_d = IDLE;
        endcase
        case (txState_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = txB_q[0];
            PARITY:  tx_d = txPar_q;
            default: tx_d = 1'b1;
        endcase
    end

    UartCoreFifo #(.WIDTH(DBITS), .EXP(FIFO_EXP)) txFifo (
        .clk   (clk_100MHz),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (txPop),
        .rdata (txHead),
        .full  (tx_full),
        .empty (txEmpty)
    );

    logic txOverflow_q, rxOverrun_q;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            txOverflow_q <= 1'b0;
            rxOverrun_q  <= 1'b0;
        end else begin
            if (tx_wr && tx_full) txOverflow_q <= 1'b1;
            else if (err_clr)     txOverflow_q <= 1'b0;
            if (rxPush && rx_full) rxOverrun_q <= 1'b1;
            else if (err_clr)      rxOverrun_q <= 1'b0;
        end
    end

    assign tx          = tx_q;
    assign tx_busy     = !txEmpty || (txState_q != IDLE);
    assign tx_overflow = txOverflow_q;
    assign rx_overrun  = rxOverrun_q;
endmodule

// File: tb/tb_uart_core_cfg.sv
// Bench for uart_core_cfg: TX line timing, loopback and injected RX frames checked through an
// expected-entry scoreboard, FIFO fill/overflow/overrun, reset mid-frame and divisor changes.
`timescale 1ns/1ps
module tb_uart_core_cfg;
    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        rx, tx, tx_wr, tx_full, tx_busy, tx_overflow;
    logic [7:0]  tx_data, rx_data;
    logic        rx_rd, rx_parity_err, rx_frame_err, rx_empty, rx_full, rx_overrun, err_clr;
    logic        loopMode, rxDrive, autoRead;
    logic [9:0]  monExp;

    int checks = 0;
    int failures = 0;
    logic [9:0] sbq [$];

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic       expPar;
    } TxVec;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic       badPar;
        logic       badStop;
        logic       expPerr;
        logic       expFerr;
    } RxVec;

    TxVec txVecs[6];
    RxVec rxVecs[8];

    always #5 clk_100MHz = ~clk_100MHz;
    assign rx = loopMode ? tx : rxDrive;

    uart_core_cfg #(.DBITS(8), .SB_TICK(16), .DIV_BITS(16), .FIFO_EXP(4)) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .baud_div      (baud_div),
        .parity_mode   (parity_mode),
        .rx            (rx),
        .tx            (tx),
        .tx_wr         (tx_wr),
        .tx_data       (tx_data),
        .tx_full       (tx_full),
        .tx_busy       (tx_busy),
        .tx_overflow   (tx_overflow),
        .rx_rd         (rx_rd),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_empty      (rx_empty),
        .rx_full       (rx_full),
        .rx_overrun    (rx_overrun),
        .err_clr       (err_clr)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got timeout, want event", name);
    endtask

    function automatic int period();
        return (baud_div == 16'd0) ? 1 : int'(baud_div);
    endfunction

    // Pops every RX entry the DUT presents and compares it with the oldest expectation.
    initial begin
        rx_rd = 1'b0;
        forever begin
            @(negedge clk_100MHz);
            rx_rd = 1'b0;
            if (autoRead && !reset && !rx_empty) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rx_unexpected: got 0x%0h, want no entry",
                             {rx_parity_err, rx_frame_err, rx_data});
                end else begin
                    monExp = sbq.pop_front();
                    checkOutput("rx_entry", {22'd0, rx_parity_err, rx_frame_err, rx_data}, {22'd0, monExp});
                end
                rx_rd = 1'b1;
            end
        end
    end

    task automatic sendByte(input logic [7:0] d, input logic track);
        if (track) sbq.push_back({2'b00, d});
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk_100MHz);
        tx_wr   = 1'b0;
    endtask

    task automatic waitTxFall(input string name, output int lat);
        lat = 0;
        while (tx !== 1'b0 && lat < 20000) begin
            @(negedge clk_100MHz);
            lat++;
        end
        if (tx !== 1'b0) timeoutFail(name);
    endtask

    task automatic waitTxIdle(input string name, input int budget);
        int n = 0;
        while (tx_busy && n < budget) begin
            @(negedge clk_100MHz);
            n++;
        end
        if (tx_busy) timeoutFail(name);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while ((tx_busy || sbq.size() != 0 || !rx_empty) && n < budget) begin
            @(negedge clk_100MHz);
            n++;
        end
        if (tx_busy || sbq.size() != 0 || !rx_empty) begin
            timeoutFail(name);
            sbq.delete();
        end
        repeat (4) @(negedge clk_100MHz);
    endtask

    task automatic measureLow(input string name, output int width);
        int lat;
        waitTxFall(name, lat);
        width = 0;
        while (tx === 1'b0 && width < 5000) begin
            @(negedge clk_100MHz);
            width++;
        end
    endtask

    task automatic driveBit(input logic b, input int ncyc);
        rxDrive = b;
        repeat (ncyc) @(negedge clk_100MHz);
    endtask

    // Drives one serial frame from the table onto rx and records the entry it should produce.
    task automatic applyStimulus(input RxVec v);
        int   bitCyc;
        logic par;
        bitCyc = 16 * period();
        parity_mode = v.mode;
        sbq.push_back({v.expPerr, v.expFerr, v.data});
        driveBit(1'b0, bitCyc);
        for (int i = 0; i < 8; i++) driveBit(v.data[i], bitCyc);
        if (v.mode == 2'b01 || v.mode == 2'b10) begin
            par = (v.mode == 2'b10) ? ~^v.data : ^v.data;
            driveBit(par ^ v.badPar, bitCyc);
        end
        if (v.badStop) begin
            driveBit(1'b0, 12 * period());
            driveBit(1'b1, 4 * period());
        end else driveBit(1'b1, bitCyc);
        driveBit(1'b1, bitCyc);
    endtask

    initial begin
        int         lat, p, width;
        logic [9:0] frame;
        logic       busyMid;

        reset = 1'b1; baud_div = 16'd4; parity_mode = 2'b00; rxDrive = 1'b1; loopMode = 1'b1;
        autoRead = 1'b1; tx_wr = 1'b0; tx_data = 8'h00; err_clr = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        checkOutput("reset_tx", tx, 1);
        checkOutput("reset_tx_busy", tx_busy, 0);
        checkOutput("reset_rx_empty", rx_empty, 1);
        checkOutput("reset_rx_full", rx_full, 0);
        checkOutput("reset_tx_full", tx_full, 0);
        checkOutput("reset_tx_overflow", tx_overflow, 0);
        checkOutput("reset_rx_overrun", rx_overrun, 0);
        checkOutput("reset_rx_head", {rx_parity_err, rx_frame_err, rx_data}, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk_100MHz);

        // 0xA5 on the line, mode none, divisor 4 -> 64 clocks per bit.
        p = period();
        frame = {1'b1, 8'hA5, 1'b0};
        sendByte(8'hA5, 1'b1);
        waitTxFall("tx_fall_a5", lat);
        checkOutput("tx_start_latency_ok", (lat <= p + 3), 1);
        repeat (8 * p) @(negedge clk_100MHz);
        busyMid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("tx_a5_bit%0d", i), tx, frame[i]);
            if (i == 5) busyMid = tx_busy;
            repeat (16 * p) @(negedge clk_100MHz);
        end
        checkOutput("tx_busy_mid_frame", busyMid, 1);
        checkOutput("tx_busy_after_stop", tx_busy, 0);
        waitDrain("drain_a5", 2000);

        // Loopback with parity: line parity bit and received entries.
        txVecs[0] = '{8'h00, 2'b01, 1'b0};
        txVecs[1] = '{8'hFF, 2'b01, 1'b0};
        txVecs[2] = '{8'h3C, 2'b01, 1'b0};
        txVecs[3] = '{8'h00, 2'b10, 1'b1};
        txVecs[4] = '{8'hFF, 2'b10, 1'b1};
        txVecs[5] = '{8'h3C, 2'b10, 1'b1};
        for (int i = 0; i < 6; i++) begin
            parity_mode = txVecs[i].mode;
            sendByte(txVecs[i].data, 1'b1);
            waitTxFall("tx_fall_par", lat);
            repeat (8 * p + 16 * p * 9) @(negedge clk_100MHz);
            checkOutput($sformatf("tx_parity_bit_%0d", i), tx, txVecs[i].expPar);
            waitDrain("drain_par", 3000);
        end

        // Injected frames with parity/stop faults.
        loopMode = 1'b0;
        rxVecs[0] = '{8'h01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
        rxVecs[1] = '{8'h01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1};
        rxVecs[2] = '{8'h5A, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        rxVecs[3] = '{8'h80, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        rxVecs[4] = '{8'hC3, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
        rxVecs[5] = '{8'h37, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        rxVecs[6] = '{8'h37, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
        rxVecs[7] = '{8'hE1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(rxVecs[i]);
            waitDrain("drain_rx_vec", 3000);
        end
        rxDrive = 1'b0;
        repeat (3 * p) @(negedge clk_100MHz);
        rxDrive = 1'b1;
        repeat (40 * p) @(negedge clk_100MHz);
        checkOutput("glitch_no_push", rx_empty, 1);
        applyStimulus('{8'hA5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0});
        waitDrain("drain_after_glitch", 3000);

        // FIFO fill: divisor held huge so nothing drains during the burst.
        loopMode = 1'b1; autoRead = 1'b0; parity_mode = 2'b00; baud_div = 16'd1000;
        reset = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tx_data = 8'(i * 13 + 7);
            tx_wr   = 1'b1;
            @(negedge clk_100MHz);
            if (i == 14) checkOutput("tx_full_after_15", tx_full, 0);
            if (i == 15) checkOutput("tx_full_after_16", tx_full, 1);
        end
        tx_wr = 1'b0;
        checkOutput("tx_overflow_set", tx_overflow, 1);
        baud_div = 16'd2;
        waitTxIdle("burst_idle", 12000);
        repeat (20) @(negedge clk_100MHz);
        checkOutput("rx_full_after_16", rx_full, 1);
        checkOutput("rx_overrun_before_17th", rx_overrun, 0);
        sendByte(8'hEE, 1'b0);
        waitTxIdle("frame17_idle", 2000);
        repeat (20) @(negedge clk_100MHz);
        checkOutput("rx_overrun_set", rx_overrun, 1);
        for (int i = 0; i < 16; i++) sbq.push_back({2'b00, 8'(i * 13 + 7)});
        autoRead = 1'b1;
        waitDrain("drain_burst", 500);
        err_clr = 1'b1;
        @(negedge clk_100MHz);
        err_clr = 1'b0;
        checkOutput("tx_overflow_cleared", tx_overflow, 0);
        checkOutput("rx_overrun_cleared", rx_overrun, 0);

        // Reset in the middle of data bit 3, then a clean 0x5A.
        baud_div = 16'd4;
        p = period();
        sendByte(8'hC3, 1'b0);
        waitTxFall("tx_fall_c3", lat);
        repeat (8 * p + 16 * p * 4) @(negedge clk_100MHz);
        reset = 1'b1;
        @(negedge clk_100MHz);
        checkOutput("midframe_reset_tx", tx, 1);
        checkOutput("midframe_reset_rx_empty", rx_empty, 1);
        checkOutput("midframe_reset_tx_busy", tx_busy, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk_100MHz);
        sendByte(8'h5A, 1'b1);
        waitDrain("drain_5a", 3000);

        // Start-bit width follows the divisor, with 0 behaving as 1.
        baud_div = 16'd54;
        sendByte(8'h01, 1'b1);
        measureLow("width_54", width);
        checkOutput("start_width_div54", width, 864);
        waitDrain("drain_div54", 20000);
        baud_div = 16'd4;
        repeat (10) @(negedge clk_100MHz);
        sendByte(8'h01, 1'b1);
        measureLow("width_4", width);
        checkOutput("start_width_div4", width, 64);
        waitDrain("drain_div4", 3000);
        baud_div = 16'd0;
        sendByte(8'h01, 1'b1);
        measureLow("width_0", width);
        checkOutput("start_width_div0", width, 16);
        waitDrain("drain_div0", 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
